// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants for the IF/DM unified-memory port arbiter.
package mem_port_arbiter_pkg;

    // Arbiter FSM encoding.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // Current owner of the memory port.
    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_DM = 1'b1;

    // Read data returned to a requester whose access was aborted by the watchdog.
    localparam logic [31:0] ABORT_RDATA = 32'h0;

    // Saturating increment used by the DM streak counter.
    function automatic logic [3:0] sat_inc4(input logic [3:0] cur, input logic [3:0] lim);
        return (cur >= lim) ? lim : cur + 4'd1;
    endfunction

endpackage

// File: rtl/mem_arb_watchdog.sv
// Clearable cycle counter that flags when a memory access has waited too long.
module mem_arb_watchdog #(
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam logic [7:0] TC_VAL = 8'(TIMEOUT_CYC - 1);

    logic [7:0] count_q, count_d;

    // Next count: clear wins over enable; hold once the terminal value is reached.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = 8'd0;
        end else if (en_i && (count_q != TC_VAL)) begin
            count_d = count_q + 8'd1;
        end
    end

    // Counter register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc_o = (count_q == TC_VAL);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port variable-latency memory between instruction fetch (IF)
// and the data-memory stage (DM). DM has priority, bounded by a streak limit so a
// pending IF is always served eventually. A watchdog aborts accesses that never ack.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned DM_STREAK   = 4,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,
    // Instruction-fetch requester
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_done_o,
    output logic              if_stall_o,
    // Data-memory requester
    input  logic              dm_req_i,
    input  logic              dm_we_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [DATA_W-1:0] dm_wdata_i,
    output logic [DATA_W-1:0] dm_rdata_o,
    output logic              dm_done_o,
    output logic              dm_stall_o,
    // Memory side
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              timeout_o
);

    localparam logic [3:0]        STREAK_MAX = 4'(DM_STREAK);
    localparam logic [DATA_W-1:0] ABORT_VAL  = DATA_W'(ABORT_RDATA);

    logic [1:0]        state_q, state_d;
    logic              owner_q, owner_d;
    logic [3:0]        streak_q, streak_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
    logic              timeout_q, timeout_d;

    logic              wd_clr, wd_en, wd_tc;
    logic              grant_dm;

    mem_arb_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_watchdog (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (wd_clr),
        .en_i  (wd_en),
        .tc_o  (wd_tc)
    );

    // DM wins unless IF is waiting and DM has already used up its streak.
    assign grant_dm = dm_req_i && !(if_req_i && (streak_q == STREAK_MAX));

    // FSM next-state, grant latching, response capture and watchdog control.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        streak_d    = streak_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        timeout_d   = timeout_q;
        wd_clr      = 1'b0;
        wd_en       = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                wd_clr = 1'b1;
                if (if_req_i || dm_req_i) begin
                    state_d   = ST_WAIT;
                    mem_req_d = 1'b1;
                    if (grant_dm) begin
                        owner_d     = OWN_DM;
                        mem_we_d    = dm_we_i;
                        mem_addr_d  = dm_addr_i;
                        mem_wdata_d = dm_wdata_i;
                        // Streak only counts DM grants made while IF was kept waiting.
                        streak_d    = if_req_i ? sat_inc4(streak_q, STREAK_MAX) : 4'd0;
                    end else begin
                        owner_d     = OWN_IF;
                        mem_we_d    = 1'b0;
                        mem_addr_d  = if_addr_i;
                        mem_wdata_d = '0;
                        streak_d    = 4'd0;
                    end
                end
            end
            ST_WAIT: begin
                // Ack takes precedence over a coincident watchdog expiry.
                if (mem_ack_i) begin
                    mem_req_d = 1'b0;
                    state_d   = ST_RESP;
                    if (owner_q == OWN_IF) begin
                        if_rdata_d = mem_rdata_i;
                    end else if (!mem_we_q) begin
                        dm_rdata_d = mem_rdata_i;
                    end
                end else if (wd_tc) begin
                    mem_req_d = 1'b0;
                    timeout_d = 1'b1;
                    state_d   = ST_RESP;
                    if (owner_q == OWN_IF) begin
                        if_rdata_d = ABORT_VAL;
                    end else if (!mem_we_q) begin
                        dm_rdata_d = ABORT_VAL;
                    end
                end else begin
                    wd_en = 1'b1;
                end
            end
            ST_RESP: begin
                // Requests are deliberately not sampled here.
                wd_clr  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                wd_clr    = 1'b1;
                mem_req_d = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWN_IF;
            streak_q    <= 4'd0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            streak_q    <= streak_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            timeout_q   <= timeout_d;
        end
    end

    // Completion pulses are the single RESP cycle, steered by the owner.
    always_comb begin
        if_done_o = (state_q == ST_RESP) && (owner_q == OWN_IF);
        dm_done_o = (state_q == ST_RESP) && (owner_q == OWN_DM);
    end

    assign if_stall_o  = if_req_i & ~if_done_o;
    assign dm_stall_o  = dm_req_i & ~dm_done_o;
    assign if_rdata_o  = if_rdata_q;
    assign dm_rdata_o  = dm_rdata_q;
    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a randomized run,
// each cycle compared against a transaction-level reference model.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int STREAK = 4;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst_i = 1'b0;
    logic          if_req_i = 1'b0;
    logic [AW-1:0] if_addr_i = '0;
    logic [DW-1:0] if_rdata_o;
    logic          if_done_o, if_stall_o;
    logic          dm_req_i = 1'b0;
    logic          dm_we_i = 1'b0;
    logic [AW-1:0] dm_addr_i = '0;
    logic [DW-1:0] dm_wdata_i = '0;
    logic [DW-1:0] dm_rdata_o;
    logic          dm_done_o, dm_stall_o;
    logic          mem_req_o, mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o;
    logic          mem_ack_i = 1'b0;
    logic [DW-1:0] mem_rdata_i = '0;
    logic          timeout_o;

    mem_port_arbiter #(
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .DM_STREAK   (STREAK),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .if_req_i    (if_req_i),
        .if_addr_i   (if_addr_i),
        .if_rdata_o  (if_rdata_o),
        .if_done_o   (if_done_o),
        .if_stall_o  (if_stall_o),
        .dm_req_i    (dm_req_i),
        .dm_we_i     (dm_we_i),
        .dm_addr_i   (dm_addr_i),
        .dm_wdata_i  (dm_wdata_i),
        .dm_rdata_o  (dm_rdata_o),
        .dm_done_o   (dm_done_o),
        .dm_stall_o  (dm_stall_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_ack_i   (mem_ack_i),
        .mem_rdata_i (mem_rdata_i),
        .timeout_o   (timeout_o)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // ---------------- memory responder ----------------
    logic [31:0] bmem [logic [31:0]];
    int  lat = 0;
    bit  no_ack = 0;
    bit  ack_always = 0;
    int  wcnt = 0;

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    // Acks `lat` cycles after mem_req_o is first seen (or every cycle in ack_always mode).
    always @(posedge clk) begin
        #1;
        if (ack_always) begin
            mem_ack_i   = 1'b1;
            mem_rdata_i = bmem.exists(mem_addr_o) ? bmem[mem_addr_o] : dflt(mem_addr_o);
            if (mem_req_o && mem_we_o) bmem[mem_addr_o] = mem_wdata_o;
            wcnt = 0;
        end else if (mem_req_o && !no_ack && wcnt == lat) begin
            mem_ack_i   = 1'b1;
            mem_rdata_i = bmem.exists(mem_addr_o) ? bmem[mem_addr_o] : dflt(mem_addr_o);
            if (mem_we_o) bmem[mem_addr_o] = mem_wdata_o;
            wcnt = wcnt + 1;
        end else begin
            mem_ack_i   = 1'b0;
            mem_rdata_i = 32'hDEAD_BEEF;
            wcnt = mem_req_o ? wcnt + 1 : 0;
        end
    end

    // ---------------- reference model ----------------
    logic [31:0] ref_mem [logic [31:0]];
    int          cyc = 0;
    bit          m_busy = 0;
    bit          m_own = 0;
    bit          m_we = 0;
    bit          m_abort = 0;
    bit          m_to = 0;
    int          m_streak = 0;
    int          m_grant_cyc = 0;
    int          m_done_cyc = 0;
    logic [31:0] m_addr = '0, m_wd = '0, m_rd = '0;
    logic [31:0] e_if_rd = '0, e_dm_rd = '0;
    bit          gq[$];
    int          dm_done_q[$];
    int          dm_raise_q[$];
    int          if_done_cnt = 0;

    // ---------------- requester scripts ----------------
    int          if_todo = 0, dm_todo = 0, if_gap = 0, dm_gap = 0, gap_max = 0;
    bit          if_fix = 1, dm_fix = 1, dm_we_fix = 0, lat_rand = 0;
    logic [31:0] if_addr_fix = '0, dm_addr_fix = '0, dm_wd_fix = '0;

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d: observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    // Model decision for an access starting in the current IDLE cycle.
    task automatic grant();
        bit g_dm;
        g_dm  = dm_req_i && !(if_req_i && m_streak == STREAK);
        m_own = g_dm ? OWN_DM : OWN_IF;
        if (g_dm) begin
            m_streak = if_req_i ? ((m_streak < STREAK) ? m_streak + 1 : STREAK) : 0;
            m_we = dm_we_i; m_addr = dm_addr_i; m_wd = dm_wdata_i;
        end else begin
            m_streak = 0; m_we = 0; m_addr = if_addr_i;
        end
        if (lat_rand) lat = $urandom_range(0, 4);
        m_abort = !ack_always && (no_ack || lat > TO - 1);
        m_done_cyc = cyc + 2 + (ack_always ? 0 : (m_abort ? TO - 1 : lat));
        m_grant_cyc = cyc;
        m_busy = 1;
        if (m_we) begin
            if (!m_abort) ref_mem[m_addr] = m_wd;
        end else begin
            m_rd = ref_read(m_addr);
        end
        gq.push_back(m_own);
    endtask

    // One cycle: compare outputs at the negedge, then drive requesters and update the model.
    task automatic tick();
        bit fin, e_ifd, e_dmd, e_mreq;
        @(negedge clk);
        cyc++;
        fin   = m_busy && cyc == m_done_cyc;
        e_ifd = fin && m_own == OWN_IF;
        e_dmd = fin && m_own == OWN_DM;
        if (fin) begin
            if (m_abort) m_to = 1;
            if (m_own == OWN_IF) e_if_rd = m_abort ? 32'h0 : m_rd;
            else if (!m_we) e_dm_rd = m_abort ? 32'h0 : m_rd;
        end
        e_mreq = m_busy && cyc > m_grant_cyc && cyc < m_done_cyc;
        chk("if_done", if_done_o, e_ifd);
        chk("dm_done", dm_done_o, e_dmd);
        chk("if_stall", if_stall_o, if_req_i & ~e_ifd);
        chk("dm_stall", dm_stall_o, dm_req_i & ~e_dmd);
        chk("mem_req", mem_req_o, e_mreq);
        chk("timeout", timeout_o, m_to);
        chk("if_rdata", if_rdata_o, e_if_rd);
        chk("dm_rdata", dm_rdata_o, e_dm_rd);
        if (e_mreq) begin
            chk("mem_we", mem_we_o, m_we);
            chk("mem_addr", mem_addr_o, m_addr);
            if (m_we) chk("mem_wdata", mem_wdata_o, m_wd);
        end
        if (if_done_o) if_done_cnt++;
        if (dm_done_o) dm_done_q.push_back(cyc);

        if (if_req_i) begin
            if (if_done_o) begin if_req_i = 0; if_gap = $urandom_range(0, gap_max); end
        end else if (if_todo > 0) begin
            if (if_gap > 0) if_gap--;
            else begin
                if_req_i  = 1;
                if_addr_i = if_fix ? if_addr_fix : (32'($urandom_range(0, 15)) << 2);
                if_todo--;
            end
        end
        if (dm_req_i) begin
            if (dm_done_o) begin dm_req_i = 0; dm_gap = $urandom_range(0, gap_max); end
        end else if (dm_todo > 0) begin
            if (dm_gap > 0) dm_gap--;
            else begin
                dm_req_i   = 1;
                dm_we_i    = dm_fix ? dm_we_fix : 1'($urandom_range(0, 1));
                dm_addr_i  = dm_fix ? dm_addr_fix : 32'h100 + (32'($urandom_range(0, 15)) << 2);
                dm_wdata_i = dm_fix ? dm_wd_fix : $urandom;
                dm_raise_q.push_back(cyc);
                dm_todo--;
            end
        end

        if (!m_busy) begin
            if (if_req_i || dm_req_i) grant();
        end else if (cyc == m_done_cyc) begin
            m_busy = 0;
        end
    endtask

    task automatic run(input int max_cyc);
        int n = 0;
        while (!(if_todo == 0 && dm_todo == 0 && !if_req_i && !dm_req_i && !m_busy)
               && n < max_cyc) begin
            tick();
            n++;
        end
        chk("drain", 32'(n < max_cyc), 32'd1);
    endtask

    initial begin
        bit exp_seq [6];
        exp_seq = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

        // Reset state
        @(negedge clk);
        chk("rst_mem_req", mem_req_o, 0);
        chk("rst_mem_we", mem_we_o, 0);
        chk("rst_mem_addr", mem_addr_o, 0);
        chk("rst_mem_wdata", mem_wdata_o, 0);
        chk("rst_if_done", if_done_o, 0);
        chk("rst_dm_done", dm_done_o, 0);
        chk("rst_timeout", timeout_o, 0);
        chk("rst_if_rdata", if_rdata_o, 0);
        chk("rst_dm_rdata", dm_rdata_o, 0);
        @(negedge clk);
        rst_i = 1;

        // Lone IF read
        bmem[32'h40] = 32'h8C02_0004; ref_mem[32'h40] = 32'h8C02_0004;
        lat = 2; if_addr_fix = 32'h40; if_todo = 1;
        run(30);
        chk("lone_if_rdata", if_rdata_o, 32'h8C02_0004);
        chk("lone_if_pulses", if_done_cnt, 1);

        // Simultaneous IF and DM write
        gq.delete();
        lat = 1; if_addr_fix = 32'h10;
        dm_we_fix = 1; dm_addr_fix = 32'h100; dm_wd_fix = 32'hA5A5_A5A5;
        if_todo = 1; dm_todo = 1;
        run(40);
        chk("simul_cnt", gq.size(), 2);
        if (gq.size() == 2) begin
            chk("simul_first", gq[0], OWN_DM);
            chk("simul_second", gq[1], OWN_IF);
        end

        // Starvation guard
        gq.delete();
        lat = 0; if_addr_fix = 32'h20;
        dm_we_fix = 0; dm_addr_fix = 32'h100;
        if_todo = 1; dm_todo = 6;
        run(100);
        chk("streak_cnt", gq.size(), 7);
        for (int i = 0; i < 6 && i < gq.size(); i++) chk("streak_seq", gq[i], exp_seq[i]);

        // Timeout with no ack
        bmem[32'h200] = 32'h1111_2222; ref_mem[32'h200] = 32'h1111_2222;
        no_ack = 1; dm_addr_fix = 32'h200; dm_todo = 1;
        run(40);
        no_ack = 0;
        chk("to_flag", timeout_o, 1);
        chk("to_rdata", dm_rdata_o, 0);

        // Reset in the middle of WAIT
        lat = 5; if_addr_fix = 32'h80; if_todo = 1;
        repeat (3) tick();
        chk("pre_rst_mem_req", mem_req_o, 1);
        rst_i = 0; if_req_i = 0; dm_req_i = 0; if_todo = 0;
        #1;
        chk("arst_mem_req", mem_req_o, 0);
        chk("arst_if_done", if_done_o, 0);
        chk("arst_dm_done", dm_done_o, 0);
        chk("arst_if_stall", if_stall_o, 0);
        chk("arst_dm_stall", dm_stall_o, 0);
        chk("arst_timeout", timeout_o, 0);
        m_busy = 0; m_streak = 0; m_to = 0; e_if_rd = '0; e_dm_rd = '0;
        repeat (2) @(negedge clk);
        rst_i = 1;
        lat = 2; if_addr_fix = 32'h84; if_todo = 1;
        run(30);
        chk("post_rst_if", if_rdata_o, dflt(32'h84));

        // Ack in the watchdog terminal cycle
        bmem[32'h204] = 32'h3333_4444; ref_mem[32'h204] = 32'h3333_4444;
        lat = TO - 1; dm_addr_fix = 32'h204; dm_todo = 1;
        run(40);
        chk("term_ack_rdata", dm_rdata_o, 32'h3333_4444);
        chk("term_ack_no_to", timeout_o, 0);

        // Zero-wait memory, back-to-back DM reads
        ack_always = 1; dm_addr_fix = 32'h108;
        dm_done_q.delete(); dm_raise_q.delete();
        dm_todo = 4;
        run(40);
        chk("zw_count", dm_done_q.size(), 4);
        if (dm_done_q.size() > 0 && dm_raise_q.size() > 0)
            chk("zw_latency", dm_done_q[0] - dm_raise_q[0], 2);
        for (int i = 1; i < dm_done_q.size(); i++)
            chk("zw_b2b", dm_done_q[i] - dm_done_q[i-1], 3);
        ack_always = 0;

        // Randomized traffic
        lat_rand = 1; if_fix = 0; dm_fix = 0; gap_max = 3;
        if_todo = 40; dm_todo = 40;
        run(3000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
